mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
- Arbiter for one shared memory port used by three client modules.
- Each client raises a request line. Requests join a FIFO queue in arrival order.
- Clients are granted the port one at a time. The granted client's address, write data and read/write select are muxed onto the shared memory bus.
- Sits between client modules and the single-port memory/peripheral they share.

Parameters:
- ADDR_W, 8, width of address buses.
- DATA_W, 32, width of write-data buses.
- MAX_GRANT_CYCLES, 16, grant timeout in cycles; used only when MEMCTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- requests  in  3  request lines; bit0 = client1, bit1 = client2, bit2 = client3.
- grantedAccess  out  3  one-hot grant; 000 when no client is granted.
- enabled  out  1  high while a grant is active.
- address  out  ADDR_W  muxed address to memory.
- dataToMem  out  DATA_W  muxed write data to memory.
- readWrite  out  1  muxed read/write select.
- addr1, addr2, addr3  in  ADDR_W  per-client address.
- dataToMem1, dataToMem2, dataToMem3  in  DATA_W  per-client write data.
- readWrite1, readWrite2, readWrite3  in  1  per-client read/write select.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: grantedAccess=000, enabled=0, queue empty, inQueue flags=000, state=IDLE, and the muxed outputs read 0.
- Queue:
  - FIFO of 2-bit client ids, depth 4.
  - Per-client inQueue flag.
  - A client cannot appear twice in the queue, so overflow is impossible.
- Enqueue:
  - Each cycle, the lowest-index client satisfying all of the following is pushed: request high, inQueue=0, not currently granted.
  - At most one push per cycle. Its inQueue flag is set on the same edge.
- State IDLE:
  - If the queue is non-empty: pop the head and clear its inQueue flag.
  - grantedAccess <= onehot(id); enabled <= 1; go to GRANTED.
  - Push and pop on the same edge are both honoured.
  - An empty queue stays in IDLE.
- State GRANTED:
  - If the granted client's request bit is 0: grantedAccess <= 000, enabled <= 0, go to IDLE.
  - Otherwise hold the grant.
  - enabled is therefore low for at least one cycle between consecutive grants.
- Withdrawn requests:
  - A client that drops its request while queued stays queued.
  - When popped, it is granted, then released one cycle later.
- Output mux:
  - Combinational from grantedAccess: 001 selects addr1/dataToMem1/readWrite1, 010 selects set 2, 100 selects set 3.
  - 000 drives address=0, dataToMem=0, readWrite=0.
- Latency:
  - First request from an empty, idle controller: pushed at edge N, granted at edge N+1.
  - Request drop: grant cleared at the next edge.
- Reset mid-grant: immediately clears grant, enabled, queue and state. Clients must re-request.

Optional Feature:
- Macro MEMCTRL_TIMEOUT_EN.
- When defined:
  - A grant cycle counter runs in GRANTED.
  - After MAX_GRANT_CYCLES cycles in GRANTED, the grant is forcibly released, as if the request dropped, and the controller goes to IDLE.
  - A client still holding its request is re-enqueued through the normal enqueue rule, at the tail.
- When undefined: a grant is held indefinitely while the request stays high.

Test Plan:
- Reset then requests=111, with addr1..3=A1/A2/A3, data=D1/D2/D3, rw=0/1/0:
  - Pushes occur in order 1, 2, 3.
  - First grant is grantedAccess=001, enabled=1, address=A1, dataToMem=D1, readWrite=0.
- Client holds 4 enabled cycles then drops; all clients re-raise while enabled=0:
  - Grants cycle 001→010→100→001.
  - address follows A1→A2→A3→A1, with readWrite=1 only during the 010 grant.
  - enabled is low exactly 1 cycle between grants.
- requests=000 after reset: grantedAccess stays 000, enabled=0, address=0 and dataToMem=0 indefinitely.
- Client2 raises alone, client1 raises 3 cycles later while 2 is granted:
  - 2 stays granted until it drops.
  - Then 001 is granted after 1 idle cycle.
- rst asserted during a 010 grant: outputs go to 000/0/0 asynchronously, and the queue is empty after release.
- With MEMCTRL_TIMEOUT_EN, MAX_GRANT_CYCLES=4, requests held at 011:
  - Grant alternates 001/010, each lasting 4 cycles.
  - Each grant is separated by a 1-cycle enabled=0 gap.

Source files
------------

// File: rtl/mem_controller.sv
// mem_controller: FIFO-ordered arbiter granting one of three clients a shared memory port.
// Latency: request pushed at edge N, granted at edge N+1; a dropped request releases at the next edge.
// Backpressure: clients wait queued until granted; at least one idle cycle separates grants.
// Optional: define MEMCTRL_TIMEOUT_EN to force release after MAX_GRANT_CYCLES granted cycles.

// mem_controller_fifo: small generic FIFO holding queued client ids.
// Latency: pushed entry is visible at the head on the following cycle.
// Backpressure: none; callers never push when full (the arbiter cannot overfill it).
module mem_controller_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign empty   = (count == '0);
endmodule

module mem_controller #(
  parameter int ADDR_W           = 8,
  parameter int DATA_W           = 32,
  parameter int MAX_GRANT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        requests,
  output logic [2:0]        grantedAccess,
  output logic              enabled,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataToMem,
  output logic              readWrite,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] dataToMem1,
  input  logic [DATA_W-1:0] dataToMem2,
  input  logic [DATA_W-1:0] dataToMem3,
  input  logic              readWrite1,
  input  logic              readWrite2,
  input  logic              readWrite3
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] GRANTED = 1'b1;

  logic [0:0] state;
  logic [2:0] in_queue;
  logic [2:0] push_mask;
  logic [1:0] push_id;
  logic       push_vld;
  logic       pop_vld;
  logic [1:0] q_head;
  logic       q_empty;
  logic [2:0] head_mask;
  logic       timeout_hit;
  logic       release_grant;

  // Pick the lowest-index client that is requesting, not queued and not granted.
  always_comb begin
    push_mask = 3'b000;
    push_id   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (requests[i] && !in_queue[i] && !grantedAccess[i]) begin
        push_mask = 3'b001 << i;
        push_id   = 2'(i);
      end
    end
  end

  assign push_vld  = |push_mask;
  assign pop_vld   = (state == IDLE) && !q_empty;
  assign head_mask = 3'b001 << q_head;

  mem_controller_fifo #(.W(2), .DEPTH(4)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_id),
    .pop_vld  (pop_vld),
    .pop_dat  (q_head),
    .empty    (q_empty)
  );

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_GRANT_CYCLES + 1);
  logic [CNT_W-1:0] grant_cnt;

  // Count cycles spent in GRANTED; restarts from zero at every new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 grant_cnt <= '0;
    else if (state == IDLE)  grant_cnt <= '0;
    else                     grant_cnt <= grant_cnt + 1'b1;
  end

  assign timeout_hit = (state == GRANTED) &&
                       (grant_cnt == CNT_W'(MAX_GRANT_CYCLES - 1));
`else
  // Grants never expire in this build.
  assign timeout_hit = 1'b0 & (MAX_GRANT_CYCLES > 0);
`endif

  // A grant ends when its owner drops the request or the grant times out.
  assign release_grant = |(grantedAccess & ~requests) || timeout_hit;

  // Queue membership flags: set on push, cleared when popped into a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_queue <= 3'b000;
    else     in_queue <= (in_queue | push_mask) & ~(pop_vld ? head_mask : 3'b000);
  end

  // Grant state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grantedAccess <= 3'b000;
      enabled       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_vld) begin
            grantedAccess <= head_mask;
            enabled       <= 1'b1;
            state         <= GRANTED;
          end
        end
        GRANTED: begin
          if (release_grant) begin
            grantedAccess <= 3'b000;
            enabled       <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the granted client's bus onto the shared memory port.
  always_comb begin
    address   = '0;
    dataToMem = '0;
    readWrite = 1'b0;
    case (grantedAccess)
      3'b001: begin address = addr1; dataToMem = dataToMem1; readWrite = readWrite1; end
      3'b010: begin address = addr2; dataToMem = dataToMem2; readWrite = readWrite2; end
      3'b100: begin address = addr3; dataToMem = dataToMem3; readWrite = readWrite3; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed checks of queueing, grant rotation, mux and reset for mem_controller.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Backpressure: not applicable; the bench only drives request levels.
module tb_mem_controller;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] A1 = 8'hA1;
  localparam logic [ADDR_W-1:0] A2 = 8'hA2;
  localparam logic [ADDR_W-1:0] A3 = 8'hA3;
  localparam logic [DATA_W-1:0] D1 = 32'hD1D1_0001;
  localparam logic [DATA_W-1:0] D2 = 32'hD2D2_0002;
  localparam logic [DATA_W-1:0] D3 = 32'hD3D3_0003;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        requests = 3'b000;
  logic [2:0]        grantedAccess;
  logic              enabled;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataToMem;
  logic              readWrite;

  int checks = 0;
  int errors = 0;

  logic [44:0] obs;
  assign obs = {grantedAccess, enabled, address, dataToMem, readWrite};

  mem_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_GRANT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .requests      (requests),
    .grantedAccess (grantedAccess),
    .enabled       (enabled),
    .address       (address),
    .dataToMem     (dataToMem),
    .readWrite     (readWrite),
    .addr1         (A1),
    .addr2         (A2),
    .addr3         (A3),
    .dataToMem1    (D1),
    .dataToMem2    (D2),
    .dataToMem3    (D3),
    .readWrite1    (1'b0),
    .readWrite2    (1'b1),
    .readWrite3    (1'b0)
  );

  always #5 clk = ~clk;

  // Expected {grant, enabled, address, data, rw} for a given grant vector.
  function automatic logic [44:0] exp_bus(input logic [2:0] g);
    case (g)
      3'b001:  return {g, 1'b1, A1, D1, 1'b0};
      3'b010:  return {g, 1'b1, A2, D2, 1'b1};
      3'b100:  return {g, 1'b1, A3, D3, 1'b0};
      default: return 45'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    requests = 3'b000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    requests = 3'b111;
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 45'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, 45'd0);
    end
    do_reset();
  endtask

  // Requests 111 from idle: client1 pushed first, granted one edge later.
  task automatic test_first_grant();
    do_reset();
    requests = 3'b111;
    tick();
    checks++;
    if (obs !== exp_bus(3'b000)) begin
      errors++;
      $display("FAIL first_push_no_grant: got %h expected %h", obs, exp_bus(3'b000));
    end
    tick();
    checks++;
    if (obs !== exp_bus(3'b001)) begin
      errors++;
      $display("FAIL first_grant: got %h expected %h", obs, exp_bus(3'b001));
    end
  endtask

  // Continues from test_first_grant: rotation 001 -> 010 -> 100 -> 001.
  task automatic test_rotation();
    logic [2:0] seq [3];
    seq[0] = 3'b010; seq[1] = 3'b100; seq[2] = 3'b001;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== exp_bus(3'b001)) begin
        errors++;
        $display("FAIL hold_c1_%0d: got %h expected %h", c, obs, exp_bus(3'b001));
      end
    end
    requests = 3'b110;
    tick();
    checks++;
    if (obs !== exp_bus(3'b000)) begin
      errors++;
      $display("FAIL release_c1: got %h expected %h", obs, exp_bus(3'b000));
    end
    for (int k = 0; k < 3; k++) begin
      requests = 3'b111;
      tick();
      checks++;
      if (obs !== exp_bus(seq[k])) begin
        errors++;
        $display("FAIL rot_grant_%0d: got %h expected %h", k, obs, exp_bus(seq[k]));
      end
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (obs !== exp_bus(seq[k])) begin
          errors++;
          $display("FAIL rot_hold_%0d_%0d: got %h expected %h", k, c, obs, exp_bus(seq[k]));
        end
      end
      requests = 3'b111 & ~seq[k];
      tick();
      checks++;
      if (obs !== exp_bus(3'b000)) begin
        errors++;
        $display("FAIL rot_gap_%0d: got %h expected %h", k, obs, exp_bus(3'b000));
      end
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs !== 45'd0) begin
        errors++;
        $display("FAIL idle_%0d: got %h expected %h", c, obs, 45'd0);
      end
    end
  endtask

  // Client2 alone, client1 joins while 2 is granted and waits its turn.
  task automatic test_late_join();
    do_reset();
    requests = 3'b010;
    tick();
    tick();
    tick();
    checks++;
    if (obs !== exp_bus(3'b010)) begin
      errors++;
      $display("FAIL late_c2_grant: got %h expected %h", obs, exp_bus(3'b010));
    end
    requests = 3'b011;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== exp_bus(3'b010)) begin
        errors++;
        $display("FAIL late_c2_hold_%0d: got %h expected %h", c, obs, exp_bus(3'b010));
      end
    end
    requests = 3'b001;
    tick();
    checks++;
    if (obs !== exp_bus(3'b000)) begin
      errors++;
      $display("FAIL late_gap: got %h expected %h", obs, exp_bus(3'b000));
    end
    tick();
    checks++;
    if (obs !== exp_bus(3'b001)) begin
      errors++;
      $display("FAIL late_c1_grant: got %h expected %h", obs, exp_bus(3'b001));
    end
  endtask

  // Reset asserted mid-grant with client1 queued: clears at once, queue emptied.
  task automatic test_reset_mid_grant();
    do_reset();
    requests = 3'b010;
    tick();
    tick();
    requests = 3'b011;
    tick();
    checks++;
    if (obs !== exp_bus(3'b010)) begin
      errors++;
      $display("FAIL midrst_pre: got %h expected %h", obs, exp_bus(3'b010));
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 45'd0) begin
      errors++;
      $display("FAIL midrst_async: got %h expected %h", obs, 45'd0);
    end
    requests = 3'b000;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs !== 45'd0) begin
        errors++;
        $display("FAIL midrst_queue_empty_%0d: got %h expected %h", c, obs, 45'd0);
      end
    end
  endtask

  // Requests held at 011 from idle; with the timeout, grants alternate every 4 cycles.
  task automatic test_hold_011();
    logic [2:0] exp_g [11];
`ifdef MEMCTRL_TIMEOUT_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2]  = 3'b001; exp_g[3] = 3'b001;
    exp_g[4] = 3'b000;
    exp_g[5] = 3'b010; exp_g[6] = 3'b010; exp_g[7]  = 3'b010; exp_g[8] = 3'b010;
    exp_g[9] = 3'b000;
    exp_g[10] = 3'b001;
`else
    for (int i = 0; i < 11; i++) exp_g[i] = 3'b001;
`endif
    do_reset();
    requests = 3'b011;
    tick();
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (obs !== exp_bus(exp_g[i])) begin
        errors++;
        $display("FAIL hold011_%0d: got %h expected %h", i, obs, exp_bus(exp_g[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_rotation();
    test_idle();
    test_late_join();
    test_reset_mid_grant();
    test_hold_011();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
